// File: rtl/vu_pkg.sv
// Shared types and defaults for the VU meter PWM capture block.
package vu_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } vu_state_e;

    localparam int LEVEL_W    = 7;
    localparam int HIGH_CNT_W = 15;

    localparam int DEF_TICK_DIV         = 64;
    localparam int DEF_FRAME_TICKS      = 128;
    localparam int DEF_TIMEOUT_CYCLES   = 16384;
    localparam int DEF_PEAK_HOLD_FRAMES = 256;

    // Round the measured high time to the nearest tick and clamp to full scale.
    function automatic logic [LEVEL_W-1:0] ticks_to_level(
        input logic [HIGH_CNT_W-1:0] high_cnt,
        input int unsigned           tick_div,
        input int unsigned           tick_shift,
        input int unsigned           level_max
    );
        logic [HIGH_CNT_W:0]  rounded;
        logic [LEVEL_W-1:0]   result;
        rounded = ({1'b0, high_cnt} + (HIGH_CNT_W+1)'(tick_div / 2)) >> tick_shift;
        if (rounded > (HIGH_CNT_W+1)'(level_max)) begin
            result = LEVEL_W'(level_max);
        end else begin
            result = rounded[LEVEL_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/vu_pwm_chan_decoder.sv
// One PWM capture channel: synchronizer, frame FSM, level/stuck outputs.
// Peak-hold tracking is built only when VU_PEAK_HOLD_EN is defined.
module vu_pwm_chan_decoder
    import vu_pkg::*;
#(
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int FRAME_TICKS    = DEF_FRAME_TICKS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`ifdef VU_PEAK_HOLD_EN
    ,
    parameter int PEAK_HOLD_FRAMES = DEF_PEAK_HOLD_FRAMES
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               pwm_i,
    output logic [LEVEL_W-1:0] level_o,
    output logic               level_valid_o,
    output logic               stuck_o
`ifdef VU_PEAK_HOLD_EN
    ,
    output logic [LEVEL_W-1:0] peak_o
`endif
);

    localparam int TICK_SHIFT = $clog2(TICK_DIV);
    localparam int PER_W      = $clog2(TIMEOUT_CYCLES);
    localparam int FULL_SCALE = (1 << LEVEL_W) - 1;
    localparam int LEVEL_MAX  = (FRAME_TICKS - 1 < FULL_SCALE) ? FRAME_TICKS - 1 : FULL_SCALE;

    localparam logic [PER_W-1:0]   PER_LAST  = PER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(LEVEL_MAX);

    logic                  sync1_q, sync2_q, sync3_q;
    vu_state_e             state_q, state_d;
    logic [HIGH_CNT_W-1:0] high_q, high_d;
    logic [PER_W-1:0]      per_q, per_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic                  valid_q, valid_d;
    logic                  stuck_q, stuck_d;
    logic                  rise_edge, fall_edge;
    logic [LEVEL_W-1:0]    frame_level;

    assign rise_edge   = sync2_q & ~sync3_q;
    assign fall_edge   = ~sync2_q & sync3_q;
    assign frame_level = ticks_to_level(high_q, TICK_DIV, TICK_SHIFT, LEVEL_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            state_q <= SYNC_WAIT;
            high_q  <= '0;
            per_q   <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            state_q <= state_d;
            high_q  <= high_d;
            per_q   <= per_d;
            level_q <= level_d;
            valid_q <= valid_d;
            stuck_q <= stuck_d;
        end
    end

    // Priority: disable, then a rising edge, then timeout, then normal counting.
    always_comb begin
        state_d = state_q;
        high_d  = high_q;
        per_d   = per_q;
        level_d = level_q;
        valid_d = 1'b0;
        stuck_d = stuck_q;
        if (!enable_i) begin
            state_d = SYNC_WAIT;
            high_d  = '0;
            per_d   = '0;
            stuck_d = 1'b0;
        end else if (rise_edge) begin
            if (state_q == LOW) begin
                level_d = frame_level;
                valid_d = 1'b1;
                stuck_d = 1'b0;
            end
            state_d = HIGH;
            high_d  = '0;
            per_d   = '0;
        end else if (per_q == PER_LAST) begin
            level_d = sync3_q ? LEVEL_TOP : '0;
            valid_d = 1'b1;
            stuck_d = 1'b1;
            state_d = SYNC_WAIT;
            high_d  = '0;
            per_d   = '0;
        end else begin
            per_d = per_q + PER_W'(1);
            case (state_q)
                HIGH: begin
                    if (high_q != '1) begin
                        high_d = high_q + HIGH_CNT_W'(1);
                    end
                    if (fall_edge) begin
                        state_d = LOW;
                    end
                end
                default: ;
            endcase
        end
    end

    assign level_o       = level_q;
    assign level_valid_o = valid_q;
    assign stuck_o       = stuck_q;

`ifdef VU_PEAK_HOLD_EN
    localparam int HOLD_W = $clog2(PEAK_HOLD_FRAMES + 1);

    logic [LEVEL_W-1:0] peak_q;
    logic [HOLD_W-1:0]  hold_q;

    // Peak only moves on strobes; while decaying it can never cross the new level
    // because the new level is strictly below the current peak on that path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            peak_q <= '0;
            hold_q <= '0;
        end else if (valid_d) begin
            if (level_d >= peak_q) begin
                peak_q <= level_d;
                hold_q <= HOLD_W'(PEAK_HOLD_FRAMES);
            end else if (hold_q != '0) begin
                hold_q <= hold_q - HOLD_W'(1);
            end else begin
                peak_q <= peak_q - LEVEL_W'(1);
            end
        end
    end

    assign peak_o = peak_q;
`endif

endmodule

// File: rtl/vu_pwm_decoder.sv
// Two-channel VU meter PWM capture (left/right), each channel fully independent.
// Define VU_PEAK_HOLD_EN to add the l_peak/r_peak peak-hold outputs.
module vu_pwm_decoder
    import vu_pkg::*;
#(
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int FRAME_TICKS    = DEF_FRAME_TICKS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`ifdef VU_PEAK_HOLD_EN
    ,
    parameter int PEAK_HOLD_FRAMES = DEF_PEAK_HOLD_FRAMES
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               l_VU_pwm_in,
    input  logic               r_VU_pwm_in,
    output logic [LEVEL_W-1:0] l_level,
    output logic [LEVEL_W-1:0] r_level,
    output logic               l_level_valid,
    output logic               r_level_valid,
    output logic               l_stuck,
    output logic               r_stuck
`ifdef VU_PEAK_HOLD_EN
    ,
    output logic [LEVEL_W-1:0] l_peak,
    output logic [LEVEL_W-1:0] r_peak
`endif
);

    vu_pwm_chan_decoder #(
        .TICK_DIV       (TICK_DIV),
        .FRAME_TICKS    (FRAME_TICKS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`ifdef VU_PEAK_HOLD_EN
        ,
        .PEAK_HOLD_FRAMES (PEAK_HOLD_FRAMES)
`endif
    ) u_left (
        .clk_i         (clk),
        .rst_i         (reset),
        .enable_i      (enable),
        .pwm_i         (l_VU_pwm_in),
        .level_o       (l_level),
        .level_valid_o (l_level_valid),
        .stuck_o       (l_stuck)
`ifdef VU_PEAK_HOLD_EN
        ,
        .peak_o        (l_peak)
`endif
    );

    vu_pwm_chan_decoder #(
        .TICK_DIV       (TICK_DIV),
        .FRAME_TICKS    (FRAME_TICKS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`ifdef VU_PEAK_HOLD_EN
        ,
        .PEAK_HOLD_FRAMES (PEAK_HOLD_FRAMES)
`endif
    ) u_right (
        .clk_i         (clk),
        .rst_i         (reset),
        .enable_i      (enable),
        .pwm_i         (r_VU_pwm_in),
        .level_o       (r_level),
        .level_valid_o (r_level_valid),
        .stuck_o       (r_stuck)
`ifdef VU_PEAK_HOLD_EN
        ,
        .peak_o        (r_peak)
`endif
    );

endmodule

// File: tb/tb_vu_pwm_decoder.sv
// Self-checking bench for vu_pwm_decoder: frame-driven stimulus, per-channel expected queues.
// Runs with shortened timeout/hold parameters to keep simulation short.
module tb_vu_pwm_decoder;

    localparam int TICK_DIV   = 64;
    localparam int TIMEOUT    = 4096;
    localparam int PEAK_HOLD  = 4;
    localparam int P          = 2700;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       l_pwm = 1'b0;
    logic       r_pwm = 1'b0;
    logic [6:0] l_level, r_level;
    logic       l_level_valid, r_level_valid;
    logic       l_stuck, r_stuck;
`ifdef VU_PEAK_HOLD_EN
    logic [6:0] l_peak, r_peak;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    // Expected entry: {peak[14:8], stuck[7], level[6:0]}
    logic [14:0] exp_l_q[$];
    logic [14:0] exp_r_q[$];
    logic [14:0] e_l, e_r;

    bit arm[2];
    int prev_h[2];
    int last[2];
    int pk[2];
    int hold[2];

    vu_pwm_decoder #(
        .TICK_DIV       (TICK_DIV),
        .FRAME_TICKS    (128),
        .TIMEOUT_CYCLES (TIMEOUT)
`ifdef VU_PEAK_HOLD_EN
        ,
        .PEAK_HOLD_FRAMES (PEAK_HOLD)
`endif
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .enable        (enable),
        .l_VU_pwm_in   (l_pwm),
        .r_VU_pwm_in   (r_pwm),
        .l_level       (l_level),
        .r_level       (r_level),
        .l_level_valid (l_level_valid),
        .r_level_valid (r_level_valid),
        .l_stuck       (l_stuck),
        .r_stuck       (r_stuck)
`ifdef VU_PEAK_HOLD_EN
        ,
        .l_peak        (l_peak),
        .r_peak        (r_peak)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic int lvl_of(input int h);
        int v;
        v = (h + TICK_DIV / 2) / TICK_DIV;
        return (v > 127) ? 127 : v;
    endfunction

    task automatic push(input int ch, input int lvl, input bit stk);
        logic [14:0] e;
        if (lvl >= pk[ch]) begin
            pk[ch]   = lvl;
            hold[ch] = PEAK_HOLD;
        end else if (hold[ch] > 0) begin
            hold[ch]--;
        end else begin
            pk[ch]--;
        end
        last[ch] = lvl;
        e = {7'(pk[ch]), stk, 7'(lvl)};
        if (ch == 0) exp_l_q.push_back(e);
        else         exp_r_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            arm[ch]  = 1'b0;
            last[ch] = 0;
            pk[ch]   = 0;
            hold[ch] = 0;
        end
    endtask

    // A rising edge publishes the previous frame only if a frame was already armed.
    task automatic rise_model(input int ch, input int h, input logic pin_now);
        if (enable && h > 0 && !pin_now) begin
            if (arm[ch]) push(ch, lvl_of(prev_h[ch]), 1'b0);
            arm[ch]    = 1'b1;
            prev_h[ch] = h;
        end
    endtask

    task automatic frame(input int hl, input int hr, input int period,
                         input bit tmo_l, input int rst_at, input int rst_rel);
        rise_model(0, hl, l_pwm);
        rise_model(1, hr, r_pwm);
        if (tmo_l) begin
            push(0, 127, 1'b1);
            arm[0] = 1'b0;
        end
        for (int c = 0; c < period; c++) begin
            @(posedge clk);
            #1;
            l_pwm = (c < hl);
            r_pwm = (c < hr);
            if (c == rst_at) begin
                #2;
                rst = 1'b1;
                #1;
                check("rst_async_l_level", 32'(l_level), 0);
                check("rst_async_r_level", 32'(r_level), 0);
                check("rst_async_l_stuck", 32'(l_stuck), 0);
                check("rst_async_r_valid", 32'(r_level_valid), 0);
                check("queue_empty_at_reset", 32'(exp_l_q.size() + exp_r_q.size()), 0);
                exp_l_q.delete();
                exp_r_q.delete();
                model_reset();
            end
            if (c == rst_rel) rst = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (l_level_valid) begin
                if (exp_l_q.size() == 0) begin
                    check("l_unexpected_valid", 1, 0);
                end else begin
                    e_l = exp_l_q.pop_front();
                    check("l_level", 32'(l_level), 32'(e_l[6:0]));
                    check("l_stuck", 32'(l_stuck), 32'(e_l[7]));
`ifdef VU_PEAK_HOLD_EN
                    check("l_peak", 32'(l_peak), 32'(e_l[14:8]));
`endif
                end
            end
            if (r_level_valid) begin
                if (exp_r_q.size() == 0) begin
                    check("r_unexpected_valid", 1, 0);
                end else begin
                    e_r = exp_r_q.pop_front();
                    check("r_level", 32'(r_level), 32'(e_r[6:0]));
                    check("r_stuck", 32'(r_stuck), 32'(e_r[7]));
`ifdef VU_PEAK_HOLD_EN
                    check("r_peak", 32'(r_peak), 32'(e_r[14:8]));
`endif
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("reset_l_level", 32'(l_level), 0);
        check("reset_r_level", 32'(r_level), 0);
        check("reset_l_valid", 32'(l_level_valid), 0);
        check("reset_r_stuck", 32'(r_stuck), 0);
`ifdef VU_PEAK_HOLD_EN
        check("reset_l_peak", 32'(l_peak), 0);
`endif
        rst    = 1'b0;
        enable = 1'b1;

        // Left 40-tick frames, right line idle low: two timeouts on the right.
        push(1, 0, 1'b1);
        push(1, 0, 1'b1);
        repeat (4) frame(2560, 0, P, 1'b0, -1, -1);
        check("idle_r_stuck", 32'(r_stuck), 1);
        check("idle_r_level", 32'(r_level), 0);
        check("ideal_l_level", 32'(l_level), 40);

        // Rounding boundary on both channels with simultaneous edges.
        frame(2591, 2592, P, 1'b0, -1, -1);
        frame(2592, 2591, P, 1'b0, -1, -1);
        frame(2560, 640, P, 1'b0, -1, -1);
        check("round_l_level", 32'(l_level), 41);
        check("round_r_level", 32'(r_level), 40);
        check("round_r_stuck_clr", 32'(r_stuck), 0);

        // Left held high through a timeout, then normal 10-tick frames.
        frame(P, 1000, P, 1'b1, -1, -1);
        frame(2000, 1000, P, 1'b0, -1, -1);
        check("stuck_hi_l_stuck", 32'(l_stuck), 1);
        check("stuck_hi_l_level", 32'(l_level), 127);
        frame(640, 1500, P, 1'b0, -1, -1);
        frame(640, 1500, P, 1'b0, -1, -1);
        check("recover_l_stuck", 32'(l_stuck), 0);
        check("recover_l_level", 32'(l_level), 10);

        // Capture disabled for three frames: no strobes, levels hold.
        enable = 1'b0;
        arm[0] = 1'b0;
        arm[1] = 1'b0;
        repeat (3) frame(1280, 1920, P, 1'b0, -1, -1);
        check("dis_l_level_hold", 32'(l_level), 32'(last[0]));
        check("dis_r_level_hold", 32'(r_level), 32'(last[1]));
        check("dis_l_stuck", 32'(l_stuck), 0);
        check("dis_r_stuck", 32'(r_stuck), 0);
        enable = 1'b1;
        repeat (2) frame(1280, 1920, P, 1'b0, -1, -1);
        check("reen_l_level", 32'(l_level), 20);

        // Reset asserted mid-HIGH, released once both lines are low.
        frame(2000, 1000, P, 1'b0, 300, 2010);
        frame(1000, 1500, P, 1'b0, -1, -1);
        check("post_rst_discard_l", 32'(l_level), 0);
        frame(1600, 700, P, 1'b0, -1, -1);
        frame(1000, 1000, P, 1'b0, -1, -1);
        check("post_rst_l_level", 32'(l_level), 25);
        check("post_rst_r_level", 32'(r_level), 11);

        // High then low levels: exercises peak hold and decay when built in.
        repeat (2) frame(1920, 1280, 2000, 1'b0, -1, -1);
        repeat (10) frame(320, 640, 2000, 1'b0, -1, -1);

        repeat (10) @(posedge clk);
        #2;
        check("l_queue_drained", 32'(exp_l_q.size()), 0);
        check("r_queue_drained", 32'(exp_r_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
